// File: rtl/score_sampler_multi.sv
// score_sampler_multi
// Multi-channel score sampler: each channel samples its scoring input once per
// PERIOD clock cycles and accumulates a score (level or rising-edge counting,
// saturating or wrapping). A small game FSM stops scoring once any channel
// reaches WIN_SCORE and latches the winning channel mask. Each channel drives
// an active-low hex digit showing the low nibble of its score.
module score_sampler_multi #(
   parameter int unsigned N_CH      = 2,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned PERIOD    = 20000000,
   parameter int unsigned WIN_SCORE = 10,
   parameter int unsigned SAT       = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    mode,
   input  logic [N_CH-1:0]         enable,
   input  logic [N_CH-1:0]         in,
   output logic [N_CH*CNT_W-1:0]   counts,
   output logic [N_CH*7-1:0]       seg,
   output logic [1:0]              state,
   output logic [N_CH-1:0]         winner,
   output logic                    tick
);

   localparam int unsigned SCW = $clog2(PERIOD);
   localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(PERIOD - 1);
   localparam logic [CNT_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [SCW-1:0]    sample_q;
   logic [CNT_W-1:0]  score_q [N_CH];
   logic [CNT_W-1:0]  score_d [N_CH];
   logic [N_CH-1:0]   prev_q;
   logic [N_CH-1:0]   winner_q;
   logic [N_CH-1:0]   win_hit;

   // Active-low hex digit, bit0 = a ... bit6 = g.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0:    p = 7'h40;
         4'h1:    p = 7'h79;
         4'h2:    p = 7'h24;
         4'h3:    p = 7'h30;
         4'h4:    p = 7'h19;
         4'h5:    p = 7'h12;
         4'h6:    p = 7'h02;
         4'h7:    p = 7'h78;
         4'h8:    p = 7'h00;
         4'h9:    p = 7'h10;
         4'hA:    p = 7'h08;
         4'hB:    p = 7'h03;
         4'hC:    p = 7'h46;
         4'hD:    p = 7'h21;
         4'hE:    p = 7'h06;
         default: p = 7'h0E;
      endcase
      return p;
   endfunction

   // Sample point: last cycle of each PERIOD while the game is running.
   always_comb begin
      tick = (state_q == RUN) && (sample_q == SAMPLE_LAST);
   end

   // Candidate post-tick scores and the win mask computed from them.
   always_comb begin
      win_hit = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         score_d[k] = score_q[k];
         if (enable[k] && in[k] && (!mode || !prev_q[k])) begin
            if (score_q[k] == SCORE_MAX) begin
               score_d[k] = (SAT != 0) ? SCORE_MAX : '0;
            end else begin
               score_d[k] = score_q[k] + CNT_W'(1);
            end
         end
         if ((WIN_SCORE != 0) && (32'(score_d[k]) >= WIN_SCORE)) begin
            win_hit[k] = 1'b1;
         end
      end
   end

   // Game FSM next state; start overrides everything except reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = IDLE;
         RUN:     if (tick && (|win_hit)) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (start) begin
         state_d = RUN;
      end
   end

   // Game FSM state register.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sample counter, scores, previous-sample and winner registers.
   always_ff @(posedge clock) begin
      if (!reset || start) begin
         sample_q <= '0;
         prev_q   <= '0;
         winner_q <= '0;
         for (int unsigned k = 0; k < N_CH; k++) begin
            score_q[k] <= '0;
         end
      end else if (state_q == RUN) begin
         if (tick) begin
            sample_q <= '0;
            prev_q   <= in;
            for (int unsigned k = 0; k < N_CH; k++) begin
               score_q[k] <= score_d[k];
            end
            if (|win_hit) begin
               winner_q <= win_hit;
            end
         end else begin
            sample_q <= sample_q + SCW'(1);
         end
      end
   end

   // Pack scores and their hex digits onto the output buses.
   always_comb begin
      counts = '0;
      seg    = '0;
      for (int unsigned k = 0; k < N_CH; k++) begin
         counts[k*CNT_W +: CNT_W] = score_q[k];
         seg[k*7 +: 7]            = hex7(score_q[k][3:0]);
      end
   end

   // Direct register outputs.
   always_comb begin
      state  = state_q;
      winner = winner_q;
   end

endmodule

// File: doc/score_sampler_multi.md
# score_sampler_multi

Parametrised multi-channel score sampler for the game datapath. Each channel samples a 1-bit scoring input once per programmable sample period and accumulates a per-channel score with selectable level/edge counting and saturate/wrap overflow. A small game FSM (IDLE/RUN/DONE) stops scoring when any channel reaches a win threshold and reports the winner(s). Each channel drives one hex seven-segment digit of its score's low nibble.

## Interface
- N_CH, 2, number of scoring channels (1..8)
- CNT_W, 8, score width per channel (4..16)
- PERIOD, 20000000, clock cycles per sample tick (>=2)
- WIN_SCORE, 10, threshold that ends the game; 0 disables win detection
- SAT, 1, 1 = scores saturate at 2^CNT_W-1; 0 = scores wrap to 0

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; dominates every other input
- start  in  1  level; clears scores and (re)enters RUN
- mode  in  1  0 = level counting, 1 = rising-edge counting
- enable  in  N_CH  per-channel scoring enable
- in  in  N_CH  per-channel scoring input (already synchronised)
- counts  out  N_CH*CNT_W  packed scores, channel k at [k*CNT_W +: CNT_W]
- seg  out  N_CH*7  active-low hex digit of counts[k][3:0], channel k at [k*7 +: 7], bit0=a … bit6=g
- state  out  2  00 IDLE, 01 RUN, 10 DONE
- winner  out  N_CH  channels at/above WIN_SCORE when DONE was entered
- tick  out  1  one-cycle pulse marking a sample point

## Operation
- Reset (reset==0 at a clock edge): state=IDLE, counts=0, winner=0, sample counter=0, prev-sample register=0, tick=0. seg therefore shows "0" (7'h40) on every channel.
- IDLE: sample counter held at 0, no scoring. start==1 → RUN.
- RUN: sample counter counts 0..PERIOD-1 and wraps; tick=1 exactly when counter==PERIOD-1 (one cycle every PERIOD cycles).
- On a tick edge, per channel k with enable[k]==1:
  - mode 0: increment if in[k]==1.
  - mode 1: increment if in[k]==1 and prev[k]==0.
  - Disabled channels hold their score.
- prev[k] <= in[k] at every tick edge for all channels, regardless of enable or mode.
- Overflow at 2^CNT_W-1: SAT=1 holds; SAT=0 wraps to 0.
- Win check uses the post-update score. If WIN_SCORE!=0 and any score >= WIN_SCORE, enter DONE on that same edge and set winner to all such channels. Ties are allowed: multiple winner bits.
- DONE: counts, winner frozen, sample counter held at 0, tick=0. start==1 → RUN.
- start==1 in any state (including RUN): counts=0, winner=0, prev=0, sample counter=0, state=RUN on that edge. start is level-sensitive: held high, it keeps the block cleared in RUN with no ticks.
- seg is combinational from registered counts. Hex patterns, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing
- Priority at a clock edge: reset > start > tick update.
- First tick comes PERIOD cycles after the start edge: counter is 0 in cycle 1 and PERIOD-1 in cycle PERIOD.
- Score latency: in[k] is sampled in the tick cycle. counts changes at that edge and is visible the next cycle. state/winner change on the same edge.
- Edge mode after start: prev=0, so an input already high scores once at the first tick.
- Changes to mode or enable take effect at the next tick. Toggles between ticks are not seen.
- in is only sampled at ticks. Pulses shorter than PERIOD that miss a tick are not counted (intended).
- reset mid-RUN aborts immediately; there is no partial tick.

## Test plan
- PERIOD=4, N_CH=2, mode 0, enable=11, in=01 held, start pulse → tick every 4th cycle. counts ch0=1,2,3…, ch1=0. seg ch0 shows 79, 24, 30.
- Same setup, mode 1, in[0] held high 5 ticks then low 1 tick then high → ch0 scores 1 on the first tick and 1 again on the rising tick. Total 2.
- WIN_SCORE=3, in=11 both enabled → both reach 3 on the same tick. state=10, winner=11, tick stops. A further start → counts 0, state=01.
- CNT_W=4, SAT=1, WIN_SCORE=0, 20 ticks with in=1 → ch0 sticks at 15, seg 0E. With SAT=0, ch0 reads 4 after 20 ticks.
- start asserted in the same cycle as a tick with in=1 → counts stay 0, the next tick comes 4 cycles later.
- reset=0 mid-RUN with counts=5 → next cycle state=00, counts=0, winner=0, seg=40, tick=0. enable=0 on ch1 during RUN → ch1 holds its value.
